// File: rtl/uart_rx_core_if.sv
// Register-side bundle for the UART receive engine: control fields in, received byte and flags out.
// The host/register file drives the master side and the receive core drives the slave side.
interface uart_rx_core_if #(
    parameter int DIV_W = 16
);
    logic [DIV_W-1:0] baud_div;
    logic             rx_enable;
    logic             rd_ack;
    logic             err_clr;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;
    logic             busy;

    modport master (
        output baud_div, rx_enable, rd_ack, err_clr,
        input  rx_data, rx_ready, frame_err, overrun, parity_err, busy
    );

    modport slave (
        input  baud_div, rx_enable, rd_ack, err_clr,
        output rx_data, rx_ready, frame_err, overrun, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rx, deframes 8N1 and holds one byte for the host.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (8E1).
module uart_rx_core #(
    parameter int DIV_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_i,
    uart_rx_core_if.slave    bus
);
    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [SYNC_N-1:0] sync_q;
    logic              rx_s;
    state_t            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shreg_q;
    logic [7:0]        data_q;
    logic              ready_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_N-2:0], rx_i};
    end

    assign rx_s = sync_q[SYNC_N-1];

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Clears come first so any flag set later in this block wins.
            if (bus.err_clr) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            if (bus.rd_ack) ready_q <= 1'b0;

            if (state_q != ST_IDLE && !bus.rx_enable) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.rx_enable && !rx_s) begin
                            div_q   <= bus.baud_div;
                            cnt_q   <= bus.baud_div >> 1;
                            state_q <= ST_START;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q     <= div_q;
                            bit_idx_q <= '0;
                            state_q   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else begin
                            shreg_q   <= {rx_s, shreg_q[7:1]};
                            cnt_q     <= div_q;
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else begin
                            if ((^shreg_q) ^ rx_s) parity_err_q <= 1'b1;
                            cnt_q   <= div_q;
                            state_q <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else if (rx_s) begin
                            // A read on this same edge frees the holding register for the new byte.
                            if (!ready_q || bus.rd_ack) begin
                                data_q  <= shreg_q;
                                ready_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_ready  = ready_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
endmodule
